// File: rtl/scemi_pipe_sr_adapter_if.sv
// scemi_pipe_sr_adapter_if -- groups the proxy-facing sampled vectors and the DUT-facing
// valid/ready streams of scemi_pipe_sr_adapter.
//
// Signals:
//   PROXY_IN   {ack_tag, tx_tag, tx_data} sampled by the proxy
//   PROXY_OUT  {host_ack_tag, rx_tag, rx_data} driven by the proxy
//   TX_DATA / TX_VALID / TX_READY  DUT-to-host stream
//   RX_DATA / RX_VALID / RX_READY  host-to-DUT stream (FIFO head)
//   RX_COUNT   receive FIFO occupancy
//
// Modports: master = adapter side, slave = proxy/DUT side.
interface scemi_pipe_sr_adapter_if #(
    parameter int unsigned DATA_WIDTH_IN  = 32,
    parameter int unsigned DATA_WIDTH_OUT = 32,
    parameter int unsigned DEPTH          = 4
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH_IN+1:0]  PROXY_IN;
    logic [DATA_WIDTH_OUT+1:0] PROXY_OUT;
    logic [DATA_WIDTH_IN-1:0]  TX_DATA;
    logic                      TX_VALID;
    logic                      TX_READY;
    logic [DATA_WIDTH_OUT-1:0] RX_DATA;
    logic                      RX_VALID;
    logic                      RX_READY;
    logic [CNT_W-1:0]          RX_COUNT;

    modport master (
        output PROXY_IN, TX_READY, RX_DATA, RX_VALID, RX_COUNT,
        input  PROXY_OUT, TX_DATA, TX_VALID, RX_READY
    );

    modport slave (
        input  PROXY_IN, TX_READY, RX_DATA, RX_VALID, RX_COUNT,
        output PROXY_OUT, TX_DATA, TX_VALID, RX_READY
    );

endinterface

// File: rtl/scemi_pipe_sr_adapter.sv
// scemi_pipe_sr_adapter -- turns the proxy's free-running sampled vectors into loss-free,
// duplicate-free valid/ready streams using one-bit toggle tags in each direction.
//
// Ports:
//   CLK    clock, all state updates on posedge
//   RST_N  asynchronous active-low reset
//   bus    scemi_pipe_sr_adapter_if.master:
//            PROXY_IN  out {ack_tag, tx_tag, tx_data}
//            PROXY_OUT in  {host_ack_tag, rx_tag, rx_data}
//            TX_*      DUT-to-host stream, one message per host round trip
//            RX_*      host-to-DUT stream out of a DEPTH-entry FIFO, RX_COUNT = occupancy
module scemi_pipe_sr_adapter #(
    parameter int unsigned DATA_WIDTH_IN  = 32,
    parameter int unsigned DATA_WIDTH_OUT = 32,
    parameter int unsigned DEPTH          = 4
) (
    input logic                     CLK,
    input logic                     RST_N,
    scemi_pipe_sr_adapter_if.master bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Proxy word fields; only consumed by flops, plus host_ack_tag into TX_READY.
    logic                      host_ack_tag;
    logic                      rx_tag;
    logic [DATA_WIDTH_OUT-1:0] rx_data;

    assign {host_ack_tag, rx_tag, rx_data} = bus.PROXY_OUT;

    // ---------------------------------------------------------------- receive FIFO
    logic                      last_rx_tag_q;
    logic [DATA_WIDTH_OUT-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic [CNT_W-1:0]          count_d;
    logic                      rx_new;
    logic                      rx_full;
    logic                      enq;
    logic                      deq;

    assign rx_new  = (rx_tag != last_rx_tag_q);
    assign rx_full = (count_q == FULL_COUNT);
    // Fullness is judged on the registered count: a same-cycle dequeue does not free a slot
    // for this cycle's message, it is simply retried on the next one.
    assign enq     = rx_new && !rx_full;
    assign deq     = (count_q != '0) && bus.RX_READY;

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_rx_tag_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                mem_q[wr_ptr_q] <= rx_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                last_rx_tag_q   <= rx_tag;
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------- transmit side
    typedef enum logic {
        TxIdle,
        TxBusy
    } tx_state_e;

    tx_state_e                tx_state;
    logic                     tx_tag_q;
    logic                     tx_tag_d;
    logic [DATA_WIDTH_IN-1:0] tx_data_q;
    logic [DATA_WIDTH_IN-1:0] tx_data_d;
    logic                     tx_ready;

    // The state lives in the tag pair: an outstanding message is one the host has not
    // yet acknowledged by echoing tx_tag back.
    always_comb begin
        tx_state  = (tx_tag_q == host_ack_tag) ? TxIdle : TxBusy;
        tx_tag_d  = tx_tag_q;
        tx_data_d = tx_data_q;
        tx_ready  = 1'b0;
        unique case (tx_state)
            TxIdle: begin
                tx_ready = RST_N;
                if (bus.TX_VALID) begin
                    tx_data_d = bus.TX_DATA;
                    tx_tag_d  = ~tx_tag_q;
                end
            end
            TxBusy: begin
                tx_ready = 1'b0;
            end
            default: begin
                tx_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_tag_q  <= 1'b0;
            tx_data_q <= '0;
        end else begin
            tx_tag_q  <= tx_tag_d;
            tx_data_q <= tx_data_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.PROXY_IN = {last_rx_tag_q, tx_tag_q, tx_data_q};
    assign bus.TX_READY = tx_ready;
    assign bus.RX_DATA  = mem_q[rd_ptr_q];
    assign bus.RX_VALID = (count_q != '0);
    assign bus.RX_COUNT = count_q;

endmodule

// File: tb/tb_scemi_pipe_sr_adapter.sv
// tb_scemi_pipe_sr_adapter -- directed scenarios plus randomized host/DUT traffic, all
// checked against a queue-based reference model of the adapter's observable behaviour.
module tb_scemi_pipe_sr_adapter;

    localparam int unsigned DW_IN  = 32;
    localparam int unsigned DW_OUT = 32;
    localparam int unsigned DEPTH  = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    always #5 CLK = ~CLK;

    // Host / DUT-side stimulus
    logic              rx_tag   = 1'b0;
    logic              host_ack = 1'b0;
    logic [DW_OUT-1:0] rx_data  = '0;
    logic [DW_IN-1:0]  tx_data  = '0;
    logic              tx_valid = 1'b0;
    logic              rx_ready = 1'b0;

    scemi_pipe_sr_adapter_if #(
        .DATA_WIDTH_IN (DW_IN),
        .DATA_WIDTH_OUT(DW_OUT),
        .DEPTH         (DEPTH)
    ) bus ();

    assign bus.PROXY_OUT = {host_ack, rx_tag, rx_data};
    assign bus.TX_DATA   = tx_data;
    assign bus.TX_VALID  = tx_valid;
    assign bus.RX_READY  = rx_ready;

    scemi_pipe_sr_adapter #(
        .DATA_WIDTH_IN (DW_IN),
        .DATA_WIDTH_OUT(DW_OUT),
        .DEPTH         (DEPTH)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    // Reference model: FIFO contents as a queue, the tag last accepted from the host,
    // and the message currently presented to the host.
    logic [DW_OUT-1:0] exp_q [$];
    logic              m_ack;
    logic              m_tx_tag;
    logic [DW_IN-1:0]  m_tx_data;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ack     = 1'b0;
        m_tx_tag  = 1'b0;
        m_tx_data = '0;
    endtask

    // Applies the rules for one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit                was_full;
        bit                is_new;
        logic [DW_OUT-1:0] dropped;
        was_full = (exp_q.size() == int'(DEPTH));
        is_new   = (rx_tag != m_ack);
        if (exp_q.size() != 0 && rx_ready) begin
            dropped = exp_q.pop_front();
        end
        if (is_new && !was_full) begin
            exp_q.push_back(rx_data);
            m_ack = rx_tag;
        end
        if (tx_valid && (m_tx_tag == host_ack)) begin
            m_tx_data = tx_data;
            m_tx_tag  = !m_tx_tag;
        end
    endtask

    task automatic compare_all();
        check_eq("rx_valid", bus.RX_VALID, exp_q.size() != 0);
        check_eq("rx_count", bus.RX_COUNT, exp_q.size());
        if (exp_q.size() != 0) check_eq("rx_data", bus.RX_DATA, exp_q[0]);
        check_eq("proxy_in", bus.PROXY_IN, {m_ack, m_tx_tag, m_tx_data});
        check_eq("tx_ready", bus.TX_READY, m_tx_tag == host_ack);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic toggle_rx(input logic [DW_OUT-1:0] d);
        rx_tag  = !rx_tag;
        rx_data = d;
    endtask

    initial begin
        // ---------------------------------------------------------- power-on reset
        model_reset();
        #1 RST_N = 1'b0;
        #2;
        check_eq("rst_rx_valid", bus.RX_VALID, 0);
        check_eq("rst_rx_count", bus.RX_COUNT, 0);
        check_eq("rst_tx_ready", bus.TX_READY, 0);
        check_eq("rst_proxy_in", bus.PROXY_IN, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check_eq("post_rst_tx_ready", bus.TX_READY, 1);

        // ---------------------------------------------------------- single rx message
        toggle_rx(32'hA5);
        tick();
        check_eq("single_valid", bus.RX_VALID, 1);
        check_eq("single_data", bus.RX_DATA, 32'hA5);
        check_eq("single_ack", bus.PROXY_IN[DW_IN+1], 1);
        check_eq("single_count", bus.RX_COUNT, 1);
        repeat (10) tick();
        check_eq("no_dup_count", bus.RX_COUNT, 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check_eq("single_drained", bus.RX_COUNT, 0);

        // ---------------------------------------------------------- full FIFO
        for (int i = 0; i < 5; i++) begin
            toggle_rx(32'h100 + i);
            tick();
        end
        check_eq("full_count", bus.RX_COUNT, 4);
        check_eq("full_ack_lags", bus.PROXY_IN[DW_IN+1], !rx_tag);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check_eq("full_no_same_cycle_enq", bus.RX_COUNT, 3);
        tick();
        check_eq("full_retry_count", bus.RX_COUNT, 4);
        check_eq("full_retry_ack", bus.PROXY_IN[DW_IN+1], rx_tag);
        rx_ready = 1'b1;
        repeat (4) tick();
        rx_ready = 1'b0;
        check_eq("full_drained", bus.RX_COUNT, 0);

        // ---------------------------------------------------------- tx handshake
        tx_data  = 32'h1234;
        tx_valid = 1'b1;
        tick();
        check_eq("tx_data_out", bus.PROXY_IN[DW_IN-1:0], 32'h1234);
        check_eq("tx_tag_out", bus.PROXY_IN[DW_IN], 1);
        check_eq("tx_busy_ready", bus.TX_READY, 0);
        tx_data = 32'hDEAD;
        repeat (2) tick();
        check_eq("tx_hold_data", bus.PROXY_IN[DW_IN-1:0], 32'h1234);
        tx_valid = 1'b0;
        host_ack = 1'b1;
        #1;
        check_eq("tx_ack_ready", bus.TX_READY, 1);
        tick();

        // ---------------------------------------------------------- simultaneous enq/deq
        for (int i = 0; i < 2; i++) begin
            toggle_rx(32'h200 + i);
            tick();
        end
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            toggle_rx(32'h210 + i);
            tick();
            check_eq("simul_count", bus.RX_COUNT, 2);
        end
        repeat (2) tick();
        rx_ready = 1'b0;
        check_eq("simul_drained", bus.RX_COUNT, 0);

        // ---------------------------------------------------------- reset mid-operation
        tx_data  = 32'hBEEF;
        tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            toggle_rx(32'h300 + i);
            tick();
            tx_valid = 1'b0;
        end
        check_eq("pre_rst_count", bus.RX_COUNT, 3);
        check_eq("pre_rst_busy", bus.TX_READY, 0);
        #2;
        RST_N    = 1'b0;
        rx_tag   = 1'b0;
        host_ack = 1'b0;
        rx_ready = 1'b0;
        model_reset();
        #1;
        check_eq("async_rx_valid", bus.RX_VALID, 0);
        check_eq("async_rx_count", bus.RX_COUNT, 0);
        check_eq("async_tx_ready", bus.TX_READY, 0);
        check_eq("async_proxy_in", bus.PROXY_IN, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check_eq("rerst_tx_ready", bus.TX_READY, 1);
        tick();

        // ---------------------------------------------------------- randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int bias;
            bias = (cyc < 750) ? 1 : 3;
            if (rx_tag == m_ack && ($urandom % 2) == 0) toggle_rx($urandom);
            rx_ready = ($urandom % 4) < bias;
            if (m_tx_tag != host_ack && ($urandom % 3) == 0) host_ack = m_tx_tag;
            tx_valid = ($urandom % 2) == 0;
            tx_data  = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/scemi_pipe_sr_adapter.md
SCEMI_PIPE_SR_ADAPTER -- requirements
Module: scemi_pipe_sr_adapter

Interface
- REQ-001: Parameters SHALL be:
  - DATA_WIDTH_IN, default 32: DUT-to-host message width.
  - DATA_WIDTH_OUT, default 32: host-to-DUT message width.
  - DEPTH, default 4: receive FIFO entries; power of 2, at least 2.
- REQ-002: Clocking SHALL use one clock with asynchronous, active-low reset.
- REQ-003: Ports SHALL be:
  - CLK  in  1  clock; all state updates on posedge.
  - RST_N  in  1  async active-low reset.
  - PROXY_IN  out  DATA_WIDTH_IN+2  sampled word to proxy: {ack_tag, tx_tag, tx_data}, MSB first.
  - PROXY_OUT  in  DATA_WIDTH_OUT+2  word from proxy: {host_ack_tag, rx_tag, rx_data}, MSB first.
  - TX_DATA  in  DATA_WIDTH_IN  DUT message to host.
  - TX_VALID  in  1  TX_DATA valid.
  - TX_READY  out  1  adapter can accept TX_DATA.
  - RX_DATA  out  DATA_WIDTH_OUT  FIFO head to DUT.
  - RX_VALID  out  1  FIFO non-empty.
  - RX_READY  in  1  DUT consumes head.
  - RX_COUNT  out  clog2(DEPTH)+1  FIFO occupancy.

Function
- REQ-004: The block SHALL convert the proxy's free-running sampled vectors into loss-free, duplicate-free valid/ready streams using one-bit toggle tags in each direction.
- REQ-005: PROXY_OUT SHALL be treated as quasi-static: it is sampled only on posedge and no combinational path from it to any output other than TX_READY is permitted.
- REQ-006 (rx new message): rx_new SHALL equal (rx_tag != last_rx_tag).
- REQ-007 (rx enqueue): When rx_new && count<DEPTH, the block SHALL write rx_data to the FIFO tail and set last_rx_tag <= rx_tag in the same cycle.
- REQ-008 (rx full): When rx_new && count==DEPTH, the block SHALL NOT enqueue and last_rx_tag SHALL hold, even if a dequeue occurs the same cycle; the message is retried next cycle.
- REQ-009 (rx ack): ack_tag in PROXY_IN SHALL equal last_rx_tag, registered, so the host sees the acknowledge one cycle after enqueue.
- REQ-010 (dequeue): On RX_VALID && RX_READY, the FIFO SHALL advance the head.
- REQ-011: RX_VALID SHALL equal (count!=0); RX_DATA SHALL be the head entry; both SHALL come directly from registers.
- REQ-012 (simultaneous): Enqueue and dequeue in the same cycle when 0<count<DEPTH SHALL leave count unchanged.
- REQ-013 (ordering): FIFO read/write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; ordering SHALL be strictly FIFO.
- REQ-014: Enqueue into an empty FIFO SHALL make RX_VALID 1 on the next cycle (latency 1 from the rx_tag change).
- REQ-015 (tx state): The tx side SHALL be a two-state machine:
  - IDLE when tx_tag==host_ack_tag.
  - BUSY otherwise.
- REQ-016: TX_READY SHALL be 1 only in IDLE and when RST_N is high.
- REQ-017 (tx accept): On TX_VALID && TX_READY, the block SHALL set tx_data <= TX_DATA and tx_tag <= ~tx_tag, entering BUSY.
- REQ-018 (tx hold): In BUSY, tx_data and tx_tag SHALL hold until host_ack_tag equals tx_tag, returning to IDLE; TX_VALID SHALL be ignored while BUSY.
- REQ-019 (throughput): Maximum tx throughput SHALL be one message per host round trip; maximum rx throughput SHALL be one message per rx_tag toggle.

Reset
- REQ-020: While RST_N is low, the block SHALL asynchronously clear:
  - tx_tag, last_rx_tag, tx_data, pointers and count to 0.
  - PROXY_IN to 0.
  - RX_VALID and TX_READY to 0.
  - RX_COUNT to 0.
- REQ-021: Reset asserted mid-operation SHALL discard FIFO contents and any BUSY tx message; host-side tags are expected to reset concurrently.
- REQ-022: The first posedge after RST_N deasserts SHALL see TX_READY=1, provided host_ack_tag==0.

Verification
- REQ-023 (single rx): rx_tag 0->1 with rx_data=0xA5 -> next cycle RX_VALID=1, RX_DATA=0xA5, ack_tag=1, RX_COUNT=1; rx_tag held at 1 for 10 cycles -> no duplicate entries.
- REQ-024 (full FIFO): RX_READY=0 with 5 toggles at DEPTH=4 -> RX_COUNT=4, ack_tag lags by one toggle; RX_READY=1 for 1 cycle -> 5th message enqueued the cycle after that dequeue, not the same cycle.
- REQ-025 (tx handshake): TX_DATA=0x1234, TX_VALID=1 -> PROXY_IN tx_data=0x1234, tx_tag=1, TX_READY=0; host_ack_tag set to 1 three cycles later -> TX_READY=1 on that cycle.
- REQ-026 (simultaneous): count=2 with enqueue and dequeue in the same cycle -> count stays 2 and order is preserved over 8 wrap-around messages.
- REQ-027 (reset mid-op): RST_N low with count=3 and tx BUSY -> RX_VALID=0, RX_COUNT=0, TX_READY=0, PROXY_IN=0 immediately (asynchronous).
